lsu: RTL and testbench

//  Load/store unit directly downstream of the execute stage. Takes ALUResult as the

---
 rtl/lsu.sv | 192 +++++++++++++++++++
 tb/tb_lsu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: takes the execute-stage address and store data, runs a
// req/gnt/rvalid handshake to data memory, builds byte-lane store masks/data
// and formats load data (sign/zero extension) for the result mux.
// Optional feature: define LSU_MISALIGN_TRAP_EN to complete misaligned
// halfword/word accesses immediately with err instead of issuing them.
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] read_data,
    output logic        done,
    output logic        err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t         state_q;
    logic           req_ready_q, done_q, err_q, dmem_req_q, dmem_we_q, is_load_q;
    logic [31:0]    read_data_q, dmem_addr_q, dmem_wdata_q;
    logic [3:0]     dmem_wmask_q;
    logic [2:0]     f3_q;
    logic [1:0]     off_q;
    logic [CW-1:0]  cnt_q;
    logic [3:0]     wmask_d;
    logic [31:0]    wdata_d;
    logic           trap_d;

    // Byte enables for a store of size sz at byte offset off (odd offsets truncate).
    function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   store_mask = 4'b0001 << off;
            2'b01:   store_mask = off[1] ? 4'b1100 : 4'b0011;
            default: store_mask = 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane so the mask alone picks the bytes.
    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    // Select the addressed byte/half from the memory word and extend it.
    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic        sext;
        b    = rd[{off, 3'b000} +: 8];
        h    = rd[{off[1], 4'b0000} +: 16];
        sext = ~f3[2];
        case (f3[1:0])
            2'b00:   load_fmt = {{24{b[7] & sext}}, b};
            2'b01:   load_fmt = {{16{h[15] & sext}}, h};
            default: load_fmt = rd;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfword needs an even offset, word needs offset zero.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = (off != 2'b00);
        endcase
    endfunction
`endif

    // Lane mask/data and alignment check computed from the incoming request.
    always_comb begin
        wmask_d = store_mask(funct3[1:0], addr[1:0]);
        wdata_d = store_data(funct3[1:0], wdata);
`ifdef LSU_MISALIGN_TRAP_EN
        trap_d  = misaligned(funct3[1:0], addr[1:0]);
`else
        trap_d  = 1'b0;
`endif
    end

    // Access sequencing FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            read_data_q  <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wmask_q <= '0;
            dmem_wdata_q <= '0;
            is_load_q    <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A request carrying no operation is consumed without effect.
                    if (req_valid && (mem_read || mem_write)) begin
                        req_ready_q <= 1'b0;
                        is_load_q   <= mem_read;
                        f3_q        <= funct3;
                        off_q       <= addr[1:0];
                        if (trap_d) begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            err_q       <= 1'b1;
                            read_data_q <= '0;
                        end else begin
                            state_q      <= S_REQ;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= ~mem_read;
                            dmem_addr_q  <= {addr[31:2], 2'b00};
                            dmem_wmask_q <= mem_read ? 4'b0000 : wmask_d;
                            dmem_wdata_q <= mem_read ? 32'h0 : wdata_d;
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        cnt_q      <= CW'(1);
                        if (is_load_q) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    // cnt_q numbers the WAIT cycles from 1; rvalid beats the timeout.
                    if (dmem_rvalid) begin
                        read_data_q <= load_fmt(f3_q, off_q, dmem_rdata);
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        err_q       <= 1'b0;
                    end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
                        read_data_q <= '0;
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign read_data  = read_data_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wmask = dmem_wmask_q;
    assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: table of directed vectors, hand-written reset/drop
// sequences, and randomized accesses checked against a behavioural model.
module tb_lsu;
    localparam int TO = 4;

    logic        clk, rst;
    logic        req_valid, req_ready, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, read_data;
    logic        done, err, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_gnt, dmem_rvalid;

    int tests = 0;
    int fails = 0;

    lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .read_data(read_data), .done(done), .err(err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ld/st ops, funct3, address, store data, memory word, gnt delay,
    // rvalid delay in WAIT cycles (-1 never), rvalid noise during REQ,
    // then expected latency, REQ cycles, mask, store lanes, load result, err.
    typedef struct packed {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gd;
        int          rv;
        logic        noise;
        int          e_lat;
        int          e_req;
        logic [3:0]  e_mask;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        chk_rd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural reference: derives every expectation from byte arithmetic.
    function automatic vec_t model(input vec_t vi);
        vec_t v;
        int o, sz;
        logic mis;
        logic [31:0] x;
        v   = vi;
        o   = int'(v.a[1:0]);
        sz  = int'(v.f3[1:0]);
        mis = (sz == 1 && (o % 2) == 1) || (sz >= 2 && o != 0);
        v.e_mask = 4'h0; v.e_wdata = 32'h0; v.e_rdata = 32'h0; v.e_err = 1'b0; v.chk_rd = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            v.e_lat = 1; v.e_req = 0; v.e_err = 1'b1; v.chk_rd = 1'b1;
            return v;
        end
`else
        if (mis) v.e_err = 1'b0;
`endif
        v.e_req = v.gd + 1;
        if (v.ld) begin
            v.chk_rd = 1'b1;
            if (v.rv >= 0 && v.rv < TO) begin
                v.e_lat = 3 + v.gd + v.rv;
                if (sz == 0) begin
                    x = (v.rd >> (8 * o)) & 32'hFF;
                    if (v.f3[2] == 1'b0 && x >= 32'd128) x = x - 32'd256;
                end else if (sz == 1) begin
                    x = (v.rd >> (16 * (o / 2))) & 32'hFFFF;
                    if (v.f3[2] == 1'b0 && x >= 32'd32768) x = x - 32'd65536;
                end else begin
                    x = v.rd;
                end
                v.e_rdata = x;
            end else begin
                v.e_lat = 2 + v.gd + TO;
                v.e_err = 1'b1;
            end
        end else begin
            v.e_lat = 2 + v.gd;
            if (sz == 0) begin
                v.e_mask = 4'(1 << o);
                v.e_wdata = (v.wd & 32'hFF) * 32'h01010101;
            end else if (sz == 1) begin
                v.e_mask = 4'(3 << (2 * (o / 2)));
                v.e_wdata = (v.wd & 32'hFFFF) * 32'h00010001;
            end else begin
                v.e_mask = 4'hF;
                v.e_wdata = v.wd;
            end
        end
        return v;
    endfunction

    // Drive one access and act as the memory; report what was observed.
    task automatic apply_vec(input vec_t v, input string tag);
        int lat, reqc, donec, req_seen, wait_n;
        logic granted, rdy0, rdy_after, o_we, o_err;
        logic [31:0] o_addr, o_wdata, o_rdata;
        logic [3:0] o_mask;
        lat = 0; reqc = 0; donec = 0; req_seen = 0; wait_n = 0; granted = 0;
        rdy_after = 0; o_we = 0; o_err = 0; o_addr = 0; o_wdata = 0; o_rdata = 0; o_mask = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = v.ld; mem_write = v.st;
        funct3 = v.f3; addr = v.a; wdata = v.wd;
        @(negedge clk);
        rdy0 = req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            if (dmem_req) begin
                if (req_seen == v.gd) dmem_gnt = 1'b1;
                req_seen++;
                dmem_rvalid = v.noise;
            end else if (granted && v.ld) begin
                if (wait_n == v.rv) dmem_rvalid = 1'b1;
                wait_n++;
            end
            dmem_rdata = dmem_rvalid ? v.rd : ~v.rd;
            @(negedge clk);
            if (dmem_req) begin
                reqc++;
                o_addr = dmem_addr; o_mask = dmem_wmask; o_wdata = dmem_wdata; o_we = dmem_we;
                if (dmem_gnt) granted = 1'b1;
            end
            if (done) begin
                donec++;
                if (lat == 0) begin
                    lat = c; o_err = err; o_rdata = read_data;
                end
            end
            if (lat != 0 && c == lat + 1) begin
                rdy_after = req_ready;
                break;
            end
            @(posedge clk); #1;
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk({tag, ".ready_in"}, 32'(rdy0), 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(v.e_lat));
        chk({tag, ".done_pulses"}, 32'(donec), 32'd1);
        chk({tag, ".req_cycles"}, 32'(reqc), 32'(v.e_req));
        if (v.e_req > 0) begin
            chk({tag, ".dmem_addr"}, o_addr, v.a & 32'hFFFFFFFC);
            chk({tag, ".dmem_we"}, 32'(o_we), 32'(!v.ld));
            chk({tag, ".wmask"}, 32'(o_mask), 32'(v.e_mask));
            if (!v.ld) chk({tag, ".wdata"}, o_wdata, v.e_wdata);
        end
        chk({tag, ".err"}, 32'(o_err), 32'(v.e_err));
        if (v.chk_rd) chk({tag, ".read_data"}, o_rdata, v.e_rdata);
        chk({tag, ".ready_after"}, 32'(rdy_after), 32'd1);
    endtask

    initial begin
        vec_t v;
        int dc;
        rst = 1'b1; req_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0;
        addr = 0; wdata = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;

        // Reset state
        @(negedge clk);
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.dmem_req", 32'(dmem_req), 32'd0);
        chk("rst.read_data", read_data, 32'h0);
        chk("rst.wmask", 32'(dmem_wmask), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed table
        tbl.push_back('{1,0,3'b000,32'h103,0,32'h80FFFFFF,0,0,0, 3,1,4'h0,0,32'hFFFFFF80,0,1});
        tbl.push_back('{1,0,3'b101,32'h206,0,32'hBEEF1234,0,0,0, 3,1,4'h0,0,32'h0000BEEF,0,1});
        tbl.push_back('{0,1,3'b001,32'h102,32'h1234ABCD,0,3,0,0, 5,4,4'hC,32'hABCDABCD,0,0,0});
        tbl.push_back('{1,0,3'b010,32'h200,0,32'h11111111,0,-1,0, 6,1,4'h0,0,32'h0,1,1});
        tbl.push_back('{1,0,3'b010,32'h300,0,32'hCAFEF00D,1,3,0, 7,2,4'h0,0,32'hCAFEF00D,0,1});
        tbl.push_back('{0,1,3'b010,32'h10,32'hDEADBEEF,0,0,0,0, 2,1,4'hF,32'hDEADBEEF,0,0,0});
        tbl.push_back('{0,1,3'b000,32'h7,32'h000000A5,0,0,0,0, 2,1,4'h8,32'hA5A5A5A5,0,0,0});
        tbl.push_back('{1,0,3'b001,32'h4,0,32'h12348001,0,1,0, 4,1,4'h0,0,32'hFFFF8001,0,1});
        tbl.push_back('{1,0,3'b100,32'h5,0,32'h0000F000,2,0,1, 5,3,4'h0,0,32'h000000F0,0,1});
        tbl.push_back('{1,0,3'b000,32'h2,0,32'h007F0000,0,2,0, 5,1,4'h0,0,32'h0000007F,0,1});
        tbl.push_back('{1,1,3'b010,32'h40,32'h55555555,32'h76543210,0,0,0, 3,1,4'h0,0,32'h76543210,0,1});
`ifdef LSU_MISALIGN_TRAP_EN
        tbl.push_back('{0,1,3'b001,32'h103,32'h0000BEEF,0,0,0,0, 1,0,4'h0,0,32'h0,1,1});
        tbl.push_back('{1,0,3'b010,32'h101,0,32'hA5A5A5A5,0,0,0, 1,0,4'h0,0,32'h0,1,1});
        tbl.push_back('{1,0,3'b001,32'h1,0,32'h1234ABCD,0,0,0, 1,0,4'h0,0,32'h0,1,1});
`else
        tbl.push_back('{0,1,3'b001,32'h103,32'h0000BEEF,0,0,0,0, 2,1,4'hC,32'hBEEFBEEF,0,0,0});
        tbl.push_back('{1,0,3'b010,32'h101,0,32'hA5A5A5A5,0,0,0, 3,1,4'h0,0,32'hA5A5A5A5,0,1});
        tbl.push_back('{1,0,3'b001,32'h1,0,32'h1234ABCD,0,0,0, 3,1,4'h0,0,32'hFFFFABCD,0,1});
`endif
        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // Request with no operation is dropped
        @(posedge clk); #1;
        req_valid = 1'b1; funct3 = 3'b010; addr = 32'h80;
        @(posedge clk); #1;
        req_valid = 1'b0;
        dc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || dmem_req || !req_ready) dc++;
            @(posedge clk); #1;
        end
        chk("drop.activity", 32'(dc), 32'd0);

        // Reset in WAIT aborts without done, then a store completes normally
        req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait.req_ready", 32'(req_ready), 32'd1);
        chk("rstwait.done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) dc++;
            @(posedge clk); #1;
        end
        chk("rstwait.no_done", 32'(dc), 32'd0);
        v = '{0,1,3'b010,32'h10,32'h0BADF00D,0,0,0,0, 2,1,4'hF,32'h0BADF00D,0,0,0};
        apply_vec(v, "rstwait_sw");

        // Randomized accesses against the model
        for (int n = 0; n < 60; n++) begin
            int pick;
            v = '0;
            v.ld = 1'($urandom_range(0, 1));
            v.st = v.ld ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.ld) begin
                pick = $urandom_range(0, 4);
                v.f3 = (pick < 3) ? 3'(pick) : 3'(pick + 1);
            end else begin
                v.f3 = 3'($urandom_range(0, 2));
            end
            v.a = $urandom;
            v.wd = $urandom;
            v.rd = $urandom;
            v.gd = $urandom_range(0, 3);
            v.rv = int'($urandom_range(0, 6)) - 1;
            v.noise = 1'($urandom_range(0, 1));
            apply_vec(model(v), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
